gpio_in_conditioner: RTL and testbench
======================================

// Module: gpio_in_conditioner
// PURPOSE
//   Conditions the raw GPIO input bits from the gpio_port instances before the GPMC register file samples them.
//   Per-bit operations:
//   - two-flop synchronisation into clk;
//   - optional tick-based debounce;
//   - rising/falling edge detection;
//   - sticky event flags with write-1-to-clear and a single interrupt output.
//   Sits between the gpio_port Input buses (upstream) and the input/event registers of the GPMC memory map (downstream).
// PARAMETERS
//   WIDTH    48  number of GPIO bits (6 ports x 8)
//   DIV_W    16  width of the debounce prescaler divisor
//   DB_SAMP  3   consecutive equal tick samples required to accept a new level (>=2)
// PORTS
//   clk        in   1        system clock, same domain as the GPMC controller
//   rst_n      in   1        asynchronous reset, active low
//   pin_in     in   WIDTH    raw pad inputs from gpio_port, asynchronous to clk
//   db_en      in   WIDTH    1 = debounce this bit, 0 = pass synchronised value
//   db_div     in   DIV_W    prescaler divisor; one sample tick every db_div+1 clk cycles
//   rise_en    in   WIDTH    1 = a rising edge on the bit sets its event flag
//   fall_en    in   WIDTH    1 = a falling edge on the bit sets its event flag
//   irq_mask   in   WIDTH    1 = the bit's event flag contributes to irq
//   clr_stb    in   1        one-cycle strobe: clear the event flags selected by clr_mask
//   clr_mask   in   WIDTH    write-1-to-clear mask, qualified by clr_stb
//   level_out  out  WIDTH    filtered input level (feeds the input registers)
//   event_out  out  WIDTH    sticky edge event flags
//   irq        out  1        registered OR of (event_out & irq_mask)
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//   - level_out, event_out, irq, sync flops, sample history and prescaler all go to 0.
//   - Release is synchronous to clk.
//   Synchroniser: 2 flops per bit; no logic between the stages.
//   Prescaler:
//   - counts 0..db_div; tick=1 for one cycle when count==db_div, then count wraps to 0.
//   - db_div=0 gives a tick every cycle.
//   - If db_div is changed below the current count, the counter wraps to 0 on the next cycle with no tick.
//   Filter, db_en=0:
//   - level_out[i] <= sync[i] every cycle.
//   - Latency from the first pin_in edge sampled to level_out is 3 clk.
//   Filter, db_en=1:
//   - On each tick, shift sync[i] into a DB_SAMP-deep history.
//   - When all DB_SAMP entries are equal and differ from level_out[i], level_out[i] takes that value on the same edge.
//   - Glitches shorter than DB_SAMP ticks never reach level_out.
//   - When db_en toggles, the history is kept; level_out continues from its current value with no glitch.
//   Edge detect:
//   - prev[i] <= level_out[i];
//   - rise = level_out & ~prev;
//   - fall = ~level_out & prev.
//   Event flags:
//   - set = (rise & rise_en) | (fall & fall_en).
//   - event_out[i] <= set[i] | (event_out[i] & ~(clr_stb & clr_mask[i])).
//   - If set and clear land in the same cycle, set wins; the event is never lost.
//   - event_out rises 1 clk after the level_out change.
//   irq:
//   - irq <= |(event_out & irq_mask); it follows event_out by 1 clk.
//   - Masking a pending flag drops irq on the next cycle; the flag itself is not cleared.
//   - After reset, the first level_out update from 0 to 1 produces a rising edge; this is intended.
// STRUCTURE
//   Shared package gpio_pkg holds:
//   - GPIO_WIDTH=48, GPIO_PORTS=6, GPIO_PORT_W=8;
//   - memory-map offsets for the DIR, OUT, IN, EVENT, IRQ_MASK, RISE_EN, FALL_EN and DB_DIV registers.
//   Sub-module gpio_in_bit: synchroniser, history, filter mux, prev flop and event flag for one bit.
//   - It is instantiated WIDTH times via generate.
//   - It shares a single prescaler tick, which lives in the parent.
// TESTING
//   1. Reset held, pin_in=all 1s -> all outputs 0. Release, db_en=0 -> level_out=all 1s on the 3rd clk.
//   2. db_en[0]=0, rise_en[0]=1, pin_in[0] 0->1 -> level_out[0]=1 at +3 clk, event_out[0]=1 at +4, irq=1 at +5 with irq_mask[0]=1.
//   3. db_en[5]=1, db_div=9, DB_SAMP=3: a 15-clk pulse on pin_in[5] -> level_out[5] stays 0.
//      Holding the pin at 1 for 40 clk -> level_out[5]=1 within 31+3 clk.
//   4. fall_en[7]=1, rise_en[7]=0: a 1->0 transition sets event_out[7]; a 0->1 transition leaves it unchanged.
//   5. event_out=0x3; clr_stb with clr_mask=0x1 -> event_out=0x2.
//      A new rise on bit 0 in the same cycle as clr_stb with clr_mask=0x1 -> event_out[0] stays 1.
//   6. Assert rst_n=0 mid-debounce, at tick count 5 -> all outputs 0 immediately.
//      After release, the prescaler restarts from 0 (first tick at db_div+1 clk).

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: bank geometry, GPMC register offsets and the
// per-bit configuration bundle handed to each input conditioning slice.
package gpio_pkg;

  localparam int GPIO_WIDTH  = 48;
  localparam int GPIO_PORTS  = 6;
  localparam int GPIO_PORT_W = 8;

  typedef enum logic [7:0] {
    REG_DIR      = 8'h00,
    REG_OUT      = 8'h08,
    REG_IN       = 8'h10,
    REG_EVENT    = 8'h18,
    REG_IRQ_MASK = 8'h20,
    REG_RISE_EN  = 8'h28,
    REG_FALL_EN  = 8'h30,
    REG_DB_DIV   = 8'h38
  } gpio_reg_e;

  // clr is already qualified by the clear strobe in the parent.
  typedef struct packed {
    logic db_en;
    logic rise_en;
    logic fall_en;
    logic clr;
  } gpio_bit_cfg_t;

endpackage

// File: rtl/gpio_in_bit.sv
// One GPIO input slice: 2-flop synchroniser, tick-sampled debounce history,
// filter select, edge detect and sticky event flag.
module gpio_in_bit
  import gpio_pkg::*;
#(
  parameter int DB_SAMP = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pin,
  input  logic          tick,
  input  gpio_bit_cfg_t cfg,
  output logic          level,
  output logic          evt
);

  logic               sync1_q;
  logic               sync2_q;
  logic [DB_SAMP-1:0] hist_q;
  logic [DB_SAMP-1:0] hist_d;
  logic               level_q;
  logic               level_d;
  logic               prev_q;
  logic               evt_q;
  logic               evt_d;
  logic               hist_stable;
  logic               rise;
  logic               fall;

  // History keeps shifting on every tick even while db_en=0, so enabling the
  // filter later starts from real recent samples and never glitches level.
  always_comb begin
    hist_d = hist_q;
    if (tick) begin
      hist_d = {hist_q[DB_SAMP-2:0], sync2_q};
    end
    hist_stable = (&hist_d) || (~|hist_d);

    level_d = level_q;
    if (!cfg.db_en) begin
      level_d = sync2_q;
    end else if (tick && hist_stable && (hist_d[0] != level_q)) begin
      level_d = hist_d[0];
    end

    rise  = level_q & ~prev_q;
    fall  = ~level_q & prev_q;
    // A new edge beats a simultaneous clear so no event is lost.
    evt_d = (rise & cfg.rise_en) | (fall & cfg.fall_en) | (evt_q & ~cfg.clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      level_q <= level_d;
      prev_q  <= level_q;
      evt_q   <= evt_d;
    end
  end

  assign level = level_q;
  assign evt   = evt_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: shared debounce prescaler, WIDTH per-bit slices and
// a registered interrupt built from the masked sticky event flags.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH   = GPIO_WIDTH,
  parameter int DIV_W   = 16,
  parameter int DB_SAMP = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] db_en,
  input  logic [DIV_W-1:0] db_div,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic             clr_stb,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] event_out,
  output logic             irq
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             tick;
  logic             irq_q;
  logic             irq_d;

  // Lowering db_div under the running count wraps silently instead of
  // waiting for a 2^DIV_W rollover.
  always_comb begin
    tick = (cnt_q == db_div);
    if (tick || (cnt_q > db_div)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    irq_d = |(event_out & irq_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_bit_cfg_t cfg;

    assign cfg = '{db_en:   db_en[i],
                   rise_en: rise_en[i],
                   fall_en: fall_en[i],
                   clr:     clr_stb & clr_mask[i]};

    gpio_in_bit #(
      .DB_SAMP (DB_SAMP)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (pin_in[i]),
      .tick  (tick),
      .cfg   (cfg),
      .level (level_out[i]),
      .evt   (event_out[i])
    );
  end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: directed scenarios with literal expectations
// plus random traffic, all checked every cycle against a behavioural model.
module tb_gpio_in_conditioner;

  localparam int W    = 48;
  localparam int DIVW = 16;
  localparam int DB   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    pin_in = '1;
  logic [W-1:0]    db_en = '0;
  logic [DIVW-1:0] db_div = '0;
  logic [W-1:0]    rise_en = '0;
  logic [W-1:0]    fall_en = '0;
  logic [W-1:0]    irq_mask = '0;
  logic            clr_stb = 1'b0;
  logic [W-1:0]    clr_mask = '0;
  logic [W-1:0]    level_out;
  logic [W-1:0]    event_out;
  logic            irq;

  int n_vec = 0;
  int n_err = 0;

  gpio_in_conditioner #(
    .WIDTH   (W),
    .DIV_W   (DIVW),
    .DB_SAMP (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin_in    (pin_in),
    .db_en     (db_en),
    .db_div    (db_div),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .irq_mask  (irq_mask),
    .clr_stb   (clr_stb),
    .clr_mask  (clr_mask),
    .level_out (level_out),
    .event_out (event_out),
    .irq       (irq)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pad values wait two clocks in a delay line before they count as synced;
  // debounce is a run-length count of identical tick samples per bit.
  logic [W-1:0] dly_q[$];
  int           m_since;
  logic         run_val[W];
  int           run_len[W];
  logic [W-1:0] m_lvl, m_prev, m_evt;
  logic         m_irq;

  task automatic m_reset();
    dly_q.delete();
    dly_q.push_back('0);
    dly_q.push_back('0);
    m_since = 0;
    for (int i = 0; i < W; i++) begin
      run_val[i] = 1'b0;
      run_len[i] = DB;
    end
    m_lvl  = '0;
    m_prev = '0;
    m_evt  = '0;
    m_irq  = 1'b0;
  endtask

  task automatic m_step();
    logic [W-1:0] cur_sync;
    logic [W-1:0] new_lvl;
    logic [W-1:0] set;
    logic         tick;
    cur_sync = dly_q.pop_front();
    dly_q.push_back(pin_in);
    tick = (m_since == int'(db_div));
    if (tick || m_since > int'(db_div)) m_since = 0;
    else m_since = m_since + 1;
    new_lvl = m_lvl;
    for (int i = 0; i < W; i++) begin
      if (tick) begin
        if (cur_sync[i] == run_val[i]) begin
          if (run_len[i] < DB) run_len[i] = run_len[i] + 1;
        end else begin
          run_val[i] = cur_sync[i];
          run_len[i] = 1;
        end
      end
      if (!db_en[i]) new_lvl[i] = cur_sync[i];
      else if (tick && run_len[i] >= DB && run_val[i] != m_lvl[i]) new_lvl[i] = run_val[i];
    end
    set    = (m_lvl & ~m_prev & rise_en) | (~m_lvl & m_prev & fall_en);
    m_irq  = |(m_evt & irq_mask);
    m_evt  = set | (m_evt & ~(clr_stb ? clr_mask : '0));
    m_prev = m_lvl;
    m_lvl  = new_lvl;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("level_out", level_out, m_lvl);
    check("event_out", event_out, m_evt);
    check("irq", W'(irq), W'(m_irq));
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr(input logic [W-1:0] mask);
    @(negedge clk);
    clr_stb  = 1'b1;
    clr_mask = mask;
    @(negedge clk);
    clr_stb  = 1'b0;
    clr_mask = '0;
  endtask

  function automatic logic [W-1:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    int   k;

    // 1: reset with pads high, then pass-through latency
    idle(3);
    check("t1_rst_level", level_out, '0);
    check("t1_rst_event", event_out, '0);
    check("t1_rst_irq", W'(irq), '0);
    #2 rst_n = 1'b1;
    idle(2);
    check("t1_level_2clk", level_out, '0);
    idle(1);
    check("t1_level_3clk", level_out, '1);

    // 2: rising edge -> level, event, irq pipeline
    @(negedge clk);
    pin_in[0]   = 1'b0;
    rise_en[0]  = 1'b1;
    irq_mask[0] = 1'b1;
    idle(6);
    pin_in[0] = 1'b1;
    idle(2);
    check("t2_level_p2", W'(level_out[0]), '0);
    idle(1);
    check("t2_level_p3", W'(level_out[0]), W'(1));
    check("t2_event_p3", event_out, '0);
    idle(1);
    check("t2_event_p4", event_out, W'(1));
    check("t2_irq_p4", W'(irq), '0);
    idle(1);
    check("t2_irq_p5", W'(irq), W'(1));

    // 3: debounce rejects a 15-clk pulse, accepts a long hold
    db_en[5] = 1'b1;
    db_div   = 16'd9;
    pin_in[5] = 1'b0;
    idle(40);
    check("t3_settle_low", W'(level_out[5]), '0);
    pin_in[5] = 1'b1;
    idle(15);
    pin_in[5] = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= level_out[5];
    end
    check("t3_glitch_blocked", W'(seen), '0);
    pin_in[5] = 1'b1;
    idle(34);
    check("t3_hold_accepted", W'(level_out[5]), W'(1));

    // 4: falling-only event enable
    fall_en[7] = 1'b1;
    pulse_clr('1);
    @(negedge clk);
    pin_in[7] = 1'b0;
    idle(6);
    check("t4_fall_sets", W'(event_out[7]), W'(1));
    pulse_clr(W'(1) << 7);
    @(negedge clk);
    pin_in[7] = 1'b1;
    idle(6);
    check("t4_rise_ignored", W'(event_out[7]), '0);

    // 5: write-1-to-clear and set-beats-clear
    rise_en[1] = 1'b1;
    pulse_clr('1);
    @(negedge clk);
    pin_in[0] = 1'b0;
    pin_in[1] = 1'b0;
    idle(6);
    pulse_clr('1);
    @(negedge clk);
    pin_in[0] = 1'b1;
    pin_in[1] = 1'b1;
    idle(6);
    check("t5_both_set", event_out, W'(3));
    pulse_clr(W'(1));
    check("t5_clear_bit0", event_out, W'(2));
    @(negedge clk);
    pin_in[0] = 1'b0;
    idle(6);
    pin_in[0] = 1'b1;
    idle(3);
    clr_stb  = 1'b1;
    clr_mask = W'(1);
    @(negedge clk);
    clr_stb  = 1'b0;
    clr_mask = '0;
    check("t5_set_wins", event_out, W'(3));

    // random traffic, model-checked every cycle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 100 == 0) begin
        db_en    = rnd48();
        rise_en  = rnd48();
        fall_en  = rnd48();
        irq_mask = rnd48() & rnd48();
      end
      if (c % 37 == 0) db_div = DIVW'($urandom_range(0, 4));
      pin_in   = pin_in ^ (rnd48() & rnd48() & rnd48());
      clr_stb  = ($urandom_range(0, 7) == 0);
      clr_mask = rnd48();
    end
    @(negedge clk);
    clr_stb  = 1'b0;
    clr_mask = '0;

    // 6: reset mid-debounce at prescaler count 5, then restart from 0
    db_div = 16'd9;
    db_en  = '1;
    pin_in = rnd48();
    k = 0;
    while (m_since != 5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_count_reached", W'(k < 50), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_level", level_out, '0);
    check("t6_rst_event", event_out, '0);
    check("t6_rst_irq", W'(irq), '0);
    pin_in = '1;
    idle(2);
    #2 rst_n = 1'b1;
    idle(29);
    check("t6_before_3rd_tick", level_out, '0);
    idle(1);
    check("t6_at_3rd_tick", level_out, '1);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
